// File: rtl/edge_event_detect.sv
// edge_event_detect
// Multi-channel edge detector. Each channel synchronizes a raw level input
// and detects rising, falling or both edges according to a 2-bit mode.
// Each detected edge produces four things: a single-cycle pulse, a stretched
// pulse, a sticky pending flag that is cleared by ack, and a saturating
// event counter.
module edge_event_detect #(
    parameter int DATA_WIDTH   = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_BITS     = 16,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [2*DATA_WIDTH-1:0]        mode,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [DATA_WIDTH-1:0]          pulse_out,
    output logic [DATA_WIDTH-1:0]          pending,
    input  logic [DATA_WIDTH-1:0]          ack,
    input  logic                           cnt_clr,
    output logic [CNT_BITS*DATA_WIDTH-1:0] event_cnt
);

    // Stretch counter must hold the value PULSE_CYCLES itself.
    localparam int                PW         = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0]     PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0]     PULSE_ZERO = '0;
    localparam logic [PW-1:0]     PULSE_ONE  = PW'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q [DATA_WIDTH];
    logic [SYNC_STAGES-1:0] sync_d [DATA_WIDTH];
    logic [PW-1:0]          pcnt_q [DATA_WIDTH];
    logic [PW-1:0]          pcnt_d [DATA_WIDTH];
    logic [CNT_BITS-1:0]    cnt_q  [DATA_WIDTH];
    logic [CNT_BITS-1:0]    cnt_d  [DATA_WIDTH];

    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [DATA_WIDTH-1:0]  pulse_q;
    logic [DATA_WIDTH-1:0]  pulse_d;
    logic [DATA_WIDTH-1:0]  pending_q;
    logic [DATA_WIDTH-1:0]  pending_d;

    logic [DATA_WIDTH-1:0]  rise_s;
    logic [DATA_WIDTH-1:0]  fall_s;
    logic [DATA_WIDTH-1:0]  event_s;

    // Edge terms from the two oldest chain stages, qualified by the live mode.
    always_comb begin
        rise_s  = '0;
        fall_s  = '0;
        event_s = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rise_s[i]  = sync_q[i][SYNC_STAGES-2] & ~sync_q[i][SYNC_STAGES-1];
            fall_s[i]  = ~sync_q[i][SYNC_STAGES-2] & sync_q[i][SYNC_STAGES-1];
            event_s[i] = (mode[2*i] & rise_s[i]) | (mode[2*i+1] & fall_s[i]);
        end
    end

    // Next-state for sync chain, stretch counter, pending flag and event counter.
    always_comb begin
        pulse_d   = '0;
        pending_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            // Chain always shifts, even when the channel is off, so that
            // enabling a channel later never reacts to stale history.
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], data_in[i]};

            // A new event reloads the full window, so there is no gap on retrigger.
            if (event_s[i]) begin
                pcnt_d[i] = PULSE_LOAD;
            end else if (pcnt_q[i] != PULSE_ZERO) begin
                pcnt_d[i] = pcnt_q[i] - PULSE_ONE;
            end else begin
                pcnt_d[i] = PULSE_ZERO;
            end
            pulse_d[i] = (pcnt_d[i] != PULSE_ZERO);

            // Set has priority over ack.
            pending_d[i] = event_s[i] | (pending_q[i] & ~ack[i]);

            // A clear coincident with an event keeps that event as count 1.
            if (event_s[i]) begin
                if (cnt_clr) begin
                    cnt_d[i] = CNT_ONE;
                end else if (cnt_q[i] == CNT_MAX) begin
                    cnt_d[i] = cnt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (cnt_clr) begin
                cnt_d[i] = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                sync_q[i] <= '0;
                pcnt_q[i] <= PULSE_ZERO;
                cnt_q[i]  <= CNT_ZERO;
            end
            data_out_q <= '0;
            pulse_q    <= '0;
            pending_q  <= '0;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                sync_q[i] <= sync_d[i];
                pcnt_q[i] <= pcnt_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            data_out_q <= event_s;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
        end
    end

    // Flatten per-channel counters onto the output bus.
    always_comb begin
        event_cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            event_cnt[CNT_BITS*i +: CNT_BITS] = cnt_q[i];
        end
    end

    assign data_out  = data_out_q;
    assign pulse_out = pulse_q;
    assign pending   = pending_q;

endmodule

// File: doc/edge_event_detect.md
EDGE_EVENT_DETECT -- requirements
Module: edge_event_detect

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8: number of independent channels.
- SYNC_STAGES, default 2: synchronizer depth, legal range 2 or more.
- CNT_BITS, default 16: width of each per-channel event counter.
- PULSE_CYCLES, default 1: length of the stretched pulse in cycles, legal range 1 or more.

REQ-002 Ports SHALL be:
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_WIDTH  raw level inputs.
- mode  in  2*DATA_WIDTH  per-channel mode; channel i uses bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 both edges.
- data_out  out  DATA_WIDTH  registered single-cycle event pulse.
- pulse_out  out  DATA_WIDTH  stretched event pulse.
- pending  out  DATA_WIDTH  sticky event flag.
- ack  in  DATA_WIDTH  clears pending, per channel.
- cnt_clr  in  1  clears all event counters.
- event_cnt  out  CNT_BITS*DATA_WIDTH  per-channel counters; channel i at [CNT_BITS*(i+1)-1:CNT_BITS*i].

REQ-003 Reset SHALL be asynchronous and active-high, and clk SHALL be the only clock.

Function
REQ-004 Each channel SHALL have a shift chain s[0..SYNC_STAGES-1]; s[0] samples data_in every cycle.

REQ-005 The per-channel edge term SHALL be computed from the last two chain stages, new = s[SYNC_STAGES-2] and old = s[SYNC_STAGES-1]:
- rise = new & ~old
- fall = ~new & old
- event = (mode[0] & rise) | (mode[1] & fall)

REQ-006 data_out[i] SHALL be the registered event term. It is high exactly one cycle per detected edge. It asserts on the SYNC_STAGES-th rising clk edge, counting the edge that first samples the new data_in level.

REQ-007 The sync chain SHALL shift in every mode, including 00. Enabling a channel therefore never acts on stale history.

REQ-008 A mode change SHALL affect only events registered on the clock edge after the change is presented.

REQ-009 In mode 11, a rise followed by a fall on consecutive chain samples SHALL produce two data_out pulses on consecutive cycles.

REQ-010 pulse_out[i] SHALL:
- go high on the same edge as data_out[i];
- stay high for exactly PULSE_CYCLES cycles, using a per-channel down-counter;
- restart the full PULSE_CYCLES window on a new event while still high, with no gap.

REQ-011 pending[i] SHALL set on the same edge as data_out[i] and clear on the edge after ack[i] is sampled high. An event and an ack in the same cycle SHALL leave pending[i]=1 (set wins).

REQ-012 event_cnt[i] SHALL increment by 1 on the same edge as data_out[i]. It saturates at 2^CNT_BITS-1 and never wraps.

REQ-013 cnt_clr SHALL zero all counters on the next edge. cnt_clr coincident with an event on channel i SHALL load event_cnt[i]=1, so the event is not lost.

REQ-014 Channels SHALL be fully independent. No event, ack or count on one channel affects another.

Reset
REQ-015 While reset is high, the following SHALL all be 0, immediately and regardless of clk: the sync chain, data_out, pulse_out, stretch counters, pending and event_cnt.

REQ-016 A data_in bit held high through reset release SHALL yield one rise event at the SYNC_STAGES-th edge after release, in modes 01 and 11.

REQ-017 Reset asserted mid-stretch or mid-pending SHALL abort it. No residual pulse, flag or count survives.

Verification
REQ-018 Rise latency: DATA_WIDTH=8, SYNC_STAGES=3, mode=all 01; data_in[0] goes 0->1 before edge N -> data_out[0] high only in the cycle after edge N+2, event_cnt[0]=1, pending[0]=1.

REQ-019 Both-edges pulse: mode ch2=11; a 1-cycle high glitch on data_in[2] -> data_out[2] high two consecutive cycles, event_cnt[2]=2; mode 00 on the same stimulus -> no outputs change.

REQ-020 Stretch retrigger: PULSE_CYCLES=4; events on ch1 spaced 2 cycles apart -> pulse_out[1] high continuously for 6 cycles, then low.

REQ-021 Counter saturation and clear: CNT_BITS=2; 5 rises on ch3 -> event_cnt[3]=3. Then cnt_clr coincident with a rise -> event_cnt[3]=1.

REQ-022 Pending race: ack[4] asserted in the cycle of a ch4 event -> pending[4] stays 1; ack[4] on the next cycle -> pending[4]=0.

REQ-023 Async reset: reset asserted between clk edges during an active stretch with pending=1 and count=2 -> all outputs 0 before the next clk edge. data_in held high through release -> one rise event SYNC_STAGES edges later.
